act_argmax: RTL and testbench
=============================

# act_argmax

Sequential classifier stage directly downstream of the fully-connected `mat_mul` layer. It captures the W-element activation vector produced by the final layer and scans it one element per clock. It returns the index and value of the largest signed element through a valid/ready handshake. This is the network's final prediction output, driven by the layer's `flag` as `in_valid`.

## Interface
Parameters:
- `N`, default 32: element width, signed fixed-point, same format as the layer output.
- `W`, default 16: vector length, at least 1.
- `IW`, default `$clog2(W)` (minimum 1): index width, derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in_vec` holds a complete vector.
- `in_ready`  out  1  block can accept a vector.
- `in_vec`  in  signed [N-1:0] [W]  activation vector.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_idx`  out  [IW-1:0]  index of the maximum element.
- `out_max`  out  signed [N-1:0]  value of the maximum element.
- `busy`  out  1  high while scanning or holding a result.

## Operation
- Reset: asynchronous assertion of `rst_n` low forces IDLE immediately.
  - All registers, including the captured vector, are cleared.
  - `out_valid`=0, `out_idx`=0, `out_max`=0, `busy`=0.
  - `in_ready`=1 while in reset and after release.
- States: IDLE, SCAN, HOLD. `in_ready` = (state==IDLE). `busy` = (state!=IDLE).
- IDLE: on `in_valid && in_ready`:
  - Register all W elements into `vec`.
  - `best_val` <= `vec[0]`, `best_idx` <= 0, `cnt` <= 1.
  - Go to SCAN, or to HOLD directly if W==1.
- SCAN: each cycle compare `vec[cnt]` against `best_val`.
  - Signed, strict greater-than. If larger, `best_val`/`best_idx` <= `vec[cnt]`/`cnt`.
  - `cnt` increments. After comparing element W-1, go to HOLD.
- Ties: strict compare, so the lowest index holding the maximum wins.
- Arithmetic: full N-bit signed compare; no truncation or saturation.
  - Negative values are handled even though ReLU output is normally ≥0.
- HOLD: `out_valid`=1. `out_idx`/`out_max` are driven from `best_idx`/`best_val` and stay stable while `out_valid` is high and `out_ready` is low.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. The vector is not re-captured, and no queueing occurs.
- `in_vec` may change freely after the accepting edge, because the block works only from `vec`.
- `out_idx`/`out_max` are unspecified while `out_valid`=0. The bench checks them only under `out_valid`.
- Reset mid-SCAN or mid-HOLD: the result is discarded, and no `out_valid` pulse appears after reset release.

## Timing
- Acceptance at rising edge k (`in_valid`&&`in_ready` sampled high).
- `in_ready` drops after edge k.
- SCAN occupies edges k+1 … k+W-1.
- `out_valid` rises after edge k+W-1: latency W-1 cycles (15 for W=16). For W=1, it rises after edge k.
- `out_ready` may be held high in advance. HOLD then lasts exactly one cycle.
- `in_ready` returns high after the edge that completes the output handshake.
- Minimum throughput: one vector per W+1 cycles with `out_ready` tied high.
- No combinational path from `in_valid` to `out_valid`. `in_ready` depends only on state.

## Test plan
- Reset: assert `rst_n`=0 mid-SCAN → next cycle `in_ready`=1, `busy`=0, `out_valid`=0. After release, no spurious `out_valid` for 20 cycles.
- Single max, W=16: vector all 0x00000100 except `in_vec[9]`=0x00001A00, `out_ready`=1 → `out_valid` exactly 15 cycles after acceptance, `out_idx`=9, `out_max`=0x1A00, one-cycle HOLD.
- Ties and boundaries:
  - All-zero vector (all-negative ReLU result) → `out_idx`=0, `out_max`=0.
  - `in_vec[3]`=`in_vec[12]`=0x7FFFFFFF → `out_idx`=3.
  - Max only at index 15 → `out_idx`=15.
- Signed compare: elements -5 … -20 with `in_vec[7]`=-1 → `out_idx`=7, `out_max`=-1. `in_vec[0]`=0x80000000 with all others -2 → `out_idx`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → outputs stable, `in_ready`=0.
  - Toggle `in_vec` and hold `in_valid`=1 throughout → no re-capture.
  - Raise `out_ready` → `in_ready`=1 next cycle, and the next vector is accepted.
- Back-to-back: 100 random vectors with `in_valid` always high and random `out_ready` → every result matches the reference argmax (lowest index on ties), with no drops or duplicates.

Source files
------------

// File: rtl/act_argmax.sv
// rtl/act_argmax.sv - sequential argmax over a captured W-element signed activation vector
// One element is compared per clock; strict greater-than means the lowest index wins a tie.
module act_argmax #(
  parameter int N  = 32,
  parameter int W  = 16,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_vec [W],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_idx,
  output logic signed [N-1:0] out_max,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic signed [N-1:0] vec_q [W];
  logic signed [N-1:0] vec_d [W];
  logic signed [N-1:0] best_val_q, best_val_d;
  logic [IW-1:0]       best_idx_q, best_idx_d;
  logic [IW-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < W; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d      = in_vec;
          best_val_d = in_vec[0];
          best_idx_d = '0;
          cnt_d      = IW'(1);
          state_d    = (W == 1) ? HOLD : SCAN;
        end
      end
      SCAN: begin
        if (vec_q[cnt_q] > best_val_q) begin
          best_val_d = vec_q[cnt_q];
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == IW'(W - 1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so nothing flows combinationally from in_valid.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_idx   = best_idx_q;
  assign out_max   = best_val_q;

endmodule

// File: tb/tb_act_argmax.sv
// tb/tb_act_argmax.sv - directed and randomized back-to-back checks for act_argmax
module tb_act_argmax;

  localparam int N  = 32;
  localparam int W  = 16;
  localparam int IW = 4;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_vec [W];
  logic                out_valid;
  logic                out_ready;
  logic [IW-1:0]       out_idx;
  logic signed [N-1:0] out_max;
  logic                busy;

  int checks = 0;
  int errors = 0;

  act_argmax #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_max  (out_max),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_vec(input logic signed [N-1:0] v);
    for (int i = 0; i < W; i++) in_vec[i] = v;
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen (lat = edges after accept).
  task automatic send_vec(output int lat);
    int t;
    t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic void ref_argmax(output int idx, output logic signed [N-1:0] mx);
    mx  = in_vec[0];
    idx = 0;
    for (int i = 1; i < W; i++) begin
      if (in_vec[i] > mx) begin
        mx  = in_vec[i];
        idx = i;
      end
    end
  endfunction

  task automatic test_reset;
    int spurious;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    fill_vec('0);
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    checks++; if (out_max !== 32'sd0) begin errors++; $display("FAIL reset_out_max got %0d want 0", out_max); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end

    // Reset in the middle of a scan.
    fill_vec(32'sh100);
    in_vec[5] = 32'sh900;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscan_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midscan_reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midscan_reset_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midscan_reset_out_valid got %b want 0", out_valid); end
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL no_spurious_valid got %0d cycles want 0", spurious); end
  endtask

  task automatic test_single_max;
    int lat;
    out_ready = 1'b1;
    fill_vec(32'sh100);
    in_vec[9] = 32'sh1A00;
    send_vec(lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL single_latency got %0d want 15", lat); end
    checks++; if (out_idx !== 4'd9) begin errors++; $display("FAIL single_idx got %0d want 9", out_idx); end
    checks++; if (out_max !== 32'sh1A00) begin errors++; $display("FAIL single_max got %h want 00001a00", out_max); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_hold_len got out_valid %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_ties_bounds;
    int lat;
    out_ready = 1'b1;
    fill_vec('0);
    send_vec(lat);
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL zero_idx got %0d want 0", out_idx); end
    checks++; if (out_max !== 32'sd0) begin errors++; $display("FAIL zero_max got %0d want 0", out_max); end
    @(negedge clk);

    fill_vec(32'sh10);
    in_vec[3]  = 32'sh7FFFFFFF;
    in_vec[12] = 32'sh7FFFFFFF;
    send_vec(lat);
    checks++; if (out_idx !== 4'd3) begin errors++; $display("FAIL tie_idx got %0d want 3", out_idx); end
    checks++; if (out_max !== 32'sh7FFFFFFF) begin errors++; $display("FAIL tie_max got %h want 7fffffff", out_max); end
    @(negedge clk);

    fill_vec(32'sd1);
    in_vec[15] = 32'sd2;
    send_vec(lat);
    checks++; if (out_idx !== 4'd15) begin errors++; $display("FAIL last_idx got %0d want 15", out_idx); end
    checks++; if (out_max !== 32'sd2) begin errors++; $display("FAIL last_max got %0d want 2", out_max); end
    @(negedge clk);
  endtask

  task automatic test_signed;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < W; i++) in_vec[i] = 32'(-5 - i);
    in_vec[7] = -32'sd1;
    send_vec(lat);
    checks++; if (out_idx !== 4'd7) begin errors++; $display("FAIL neg_idx got %0d want 7", out_idx); end
    checks++; if (out_max !== -32'sd1) begin errors++; $display("FAIL neg_max got %0d want -1", out_max); end
    @(negedge clk);

    fill_vec(-32'sd2);
    in_vec[0] = 32'sh80000000;
    send_vec(lat);
    checks++; if (out_idx !== 4'd1) begin errors++; $display("FAIL minint_idx got %0d want 1", out_idx); end
    checks++; if (out_max !== -32'sd2) begin errors++; $display("FAIL minint_max got %0d want -2", out_max); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    fill_vec(32'sh20);
    in_vec[4] = 32'sh55;
    send_vec(lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL bp_latency got %0d want 15", lat); end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      for (int j = 0; j < W; j++) in_vec[j] = $urandom;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", c, out_valid); end
      checks++; if (out_idx !== 4'd4) begin errors++; $display("FAIL bp_idx c%0d got %0d want 4", c, out_idx); end
      checks++; if (out_max !== 32'sh55) begin errors++; $display("FAIL bp_max c%0d got %h want 00000055", c, out_max); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
    end
    fill_vec(32'sh10);
    in_vec[2] = 32'sh300;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    send_vec(lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL bp_next_latency got %0d want 15", lat); end
    checks++; if (out_idx !== 4'd2) begin errors++; $display("FAIL bp_next_idx got %0d want 2", out_idx); end
    checks++; if (out_max !== 32'sh300) begin errors++; $display("FAIL bp_next_max got %h want 00000300", out_max); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int                  exp_idx_q[$];
    logic signed [N-1:0] exp_max_q[$];
    int                  sent, recvd, cyc, r, ridx, eidx;
    logic signed [N-1:0] rmax, emax;
    sent = 0;
    recvd = 0;
    cyc = 0;
    while (recvd < 100 && cyc < 10000) begin
      for (int j = 0; j < W; j++) begin
        r = int'($urandom_range(0, 15)) - 8;
        in_vec[j] = r;
      end
      in_valid = (sent < 100);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        ref_argmax(ridx, rmax);
        exp_idx_q.push_back(ridx);
        exp_max_q.push_back(rmax);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_idx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_unexpected_result idx %0d max %0d with empty scoreboard", out_idx, out_max);
        end else begin
          eidx = exp_idx_q.pop_front();
          emax = exp_max_q.pop_front();
          checks++; if (out_idx !== 4'(eidx)) begin errors++; $display("FAIL b2b_idx #%0d got %0d want %0d", recvd, out_idx, eidx); end
          checks++; if (out_max !== emax) begin errors++; $display("FAIL b2b_max #%0d got %0d want %0d", recvd, out_max, emax); end
        end
        recvd++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (recvd !== 100) begin errors++; $display("FAIL b2b_count got %0d results want 100", recvd); end
    checks++; if (exp_idx_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got %0d pending want 0", exp_idx_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single_max;
    test_ties_bounds;
    test_signed;
    test_backpressure;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
